// File: rtl/seq_counter_fsm.sv
// -----------------------------------------------------------------------------
// seq_counter_fsm
//
// Moore sequence counter stepped by x. The internal state is always a plain
// binary count; the two Gray modes step that binary count and only change how
// it is presented on out. Four sequences can be selected at run time:
//   mode 00 binary up, 01 binary down, 10 Gray up, 11 Gray down.
// At the terminal value of the current direction the counter either wraps to
// the opposite end (WRAP=1, with a one-cycle wrapped pulse) or holds (WRAP=0).
//
// Parameters:
//   WIDTH   state/output width in bits (>= 2)
//   WRAP    1 = wrap at terminal value, 0 = saturate at terminal value
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (clears count, out, wrapped)
//   x        step enable, one step per rising edge while high
//   mode     sequence select (bit 0 = direction, bit 1 = Gray encoding)
//   ld       synchronous load of din, has priority over x
//   din      binary-domain load value
//   out      registered, encoded state
//   tc       combinational terminal-count flag for the current direction
//   wrapped  registered one-cycle pulse following a wrap edge
// -----------------------------------------------------------------------------
module seq_counter_fsm #(
    parameter int WIDTH = 2,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic [1:0]       mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrapped
);

    // Sequence selectors, fully decoded so every mode value is meaningful.
    localparam logic [1:0] MODE_BIN_UP   = 2'b00;
    localparam logic [1:0] MODE_BIN_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY_UP  = 2'b10;
    localparam logic [1:0] MODE_GRAY_DOWN = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             wrapped_reg;
    logic             wrapped_next;
    logic             dir_down;
    logic             gray_sel;
    logic             at_terminal;

    // Mode decode: direction and output encoding.
    always_comb begin
        dir_down = 1'b0;
        gray_sel = 1'b0;
        case (mode)
            MODE_BIN_UP: begin
                dir_down = 1'b0;
                gray_sel = 1'b0;
            end
            MODE_BIN_DOWN: begin
                dir_down = 1'b1;
                gray_sel = 1'b0;
            end
            MODE_GRAY_UP: begin
                dir_down = 1'b0;
                gray_sel = 1'b1;
            end
            MODE_GRAY_DOWN: begin
                dir_down = 1'b1;
                gray_sel = 1'b1;
            end
            default: begin
                dir_down = 1'b0;
                gray_sel = 1'b0;
            end
        endcase
    end

    // Terminal value depends on the direction currently requested, so tc
    // follows mode changes immediately even while the count is idle.
    assign at_terminal = dir_down ? (cnt_reg == ZERO) : (cnt_reg == ALL_ONES);
    assign tc          = at_terminal;

    // Next-count selection: load beats stepping; stepping at the terminal
    // value either wraps to the opposite end or holds.
    always_comb begin
        cnt_next     = cnt_reg;
        wrapped_next = 1'b0;
        if (ld) begin
            cnt_next = din;
        end else if (x) begin
            if (!at_terminal) begin
                cnt_next = dir_down ? (cnt_reg - ONE) : (cnt_reg + ONE);
            end else if (WRAP) begin
                cnt_next     = dir_down ? ALL_ONES : ZERO;
                wrapped_next = 1'b1;
            end
        end
    end

    // Gray encoding of the next count: each bit is the XOR of a bit and its
    // upper neighbour; the MSB passes straight through.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = cnt_next[gi] ^ cnt_next[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = cnt_next[WIDTH-1];

    // out is encoded from the next count so it is valid in the same cycle
    // the count lands, and a mode change alone re-encodes it at the edge.
    assign out_next = gray_sel ? gray_next : cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= ZERO;
            out_reg     <= ZERO;
            wrapped_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            out_reg     <= out_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign out     = out_reg;
    assign wrapped = wrapped_reg;

endmodule

// File: tb/tb_seq_counter_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_counter_fsm
//
// Four instances with different WIDTH/WRAP share the same stimulus:
//   inst 0: WIDTH=2 WRAP=1   inst 1: WIDTH=3 WRAP=1
//   inst 2: WIDTH=4 WRAP=1   inst 3: WIDTH=4 WRAP=0
// A counter model built from the sequence rules with integer arithmetic runs
// alongside and every instance is compared after each edge. A table of
// directed vectors and a few hand-written sequences cover the corner cases,
// followed by randomized stimulus including asynchronous resets mid-cycle.
// -----------------------------------------------------------------------------
module tb_seq_counter_fsm;

    logic       clk;
    logic       rst;
    logic       x;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] din;

    logic [1:0] out0;
    logic [2:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic       tc0, tc1, tc2, tc3;
    logic       wr0, wr1, wr2, wr3;

    seq_counter_fsm #(.WIDTH(2), .WRAP(1'b1)) dut0 (
        .clk(clk), .rst(rst), .x(x), .mode(mode), .ld(ld), .din(din[1:0]),
        .out(out0), .tc(tc0), .wrapped(wr0));
    seq_counter_fsm #(.WIDTH(3), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .x(x), .mode(mode), .ld(ld), .din(din[2:0]),
        .out(out1), .tc(tc1), .wrapped(wr1));
    seq_counter_fsm #(.WIDTH(4), .WRAP(1'b1)) dut2 (
        .clk(clk), .rst(rst), .x(x), .mode(mode), .ld(ld), .din(din),
        .out(out2), .tc(tc2), .wrapped(wr2));
    seq_counter_fsm #(.WIDTH(4), .WRAP(1'b0)) dut3 (
        .clk(clk), .rst(rst), .x(x), .mode(mode), .ld(ld), .din(din),
        .out(out3), .tc(tc3), .wrapped(wr3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs gathered into arrays so checks can loop over instances.
    logic [3:0] dout [4];
    logic       dtc  [4];
    logic       dwr  [4];
    assign dout[0] = {2'b00, out0};
    assign dout[1] = {1'b0, out1};
    assign dout[2] = out2;
    assign dout[3] = out3;
    assign dtc[0] = tc0;
    assign dtc[1] = tc1;
    assign dtc[2] = tc2;
    assign dtc[3] = tc3;
    assign dwr[0] = wr0;
    assign dwr[1] = wr1;
    assign dwr[2] = wr2;
    assign dwr[3] = wr3;

    int n_cmp;
    int n_bad;
    int n_txn;

    // ---------------- reference model ----------------
    int wid  [4] = '{2, 3, 4, 4};
    bit wrp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int m_cnt[4];
    int m_out[4];
    bit m_wr [4];

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int max_of(input int i);
        return (1 << wid[i]) - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_out[i] = 0;
            m_wr[i]  = 1'b0;
        end
    endtask

    // One rising edge of every instance, from the stepping rules.
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int top;
            bit up;
            top = max_of(i);
            up  = (mode[0] == 1'b0);
            m_wr[i] = 1'b0;
            if (ld) begin
                m_cnt[i] = int'(din) & top;
            end else if (x) begin
                if (up && m_cnt[i] < top) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end else if (!up && m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else if (wrp[i]) begin
                    m_cnt[i] = up ? 0 : top;
                    m_wr[i]  = 1'b1;
                end
            end
            m_out[i] = mode[1] ? gray_of(m_cnt[i]) : m_cnt[i];
        end
    endtask

    function automatic bit model_tc(input int i);
        if (mode[0] == 1'b0)
            return m_cnt[i] == max_of(i);
        return m_cnt[i] == 0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("out", i, int'(dout[i]), m_out[i]);
            chk("tc", i, int'(dtc[i]), int'(model_tc(i)));
            chk("wrapped", i, int'(dwr[i]), int'(m_wr[i]));
        end
    endtask

    // Drive one transaction, clock it, then compare everything 1 ns later.
    task automatic apply(input bit ax, input bit [1:0] amode, input bit ald, input bit [3:0] adin);
        x    = ax;
        mode = amode;
        ld   = ald;
        din  = adin;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        n_txn++;
        $display("txn %0d x=%0d mode=%0d ld=%0d din=%h out=%h/%h/%h/%h tc=%0d%0d%0d%0d wr=%0d%0d%0d%0d",
                 n_txn, ax, amode, ald, adin, out0, out1, out2, out3,
                 tc0, tc1, tc2, tc3, wr0, wr1, wr2, wr3);
    endtask

    // Called 1 ns after an edge: pulse rst between edges and check that the
    // outputs clear without any clock edge.
    task automatic do_reset(input bit [1:0] amode);
        x    = 1'b0;
        ld   = 1'b0;
        din  = 4'h0;
        mode = amode;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        $display("txn reset mode=%0d out=%h/%h/%h/%h wr=%0d%0d%0d%0d",
                 amode, out0, out1, out2, out3, wr0, wr1, wr2, wr3);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       rst_before;
        int       inst;
        bit       x;
        bit [1:0] mode;
        bit       ld;
        bit [3:0] din;
        int       exp_out;
        bit       exp_tc;
        bit       exp_wr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_txn = 0;
        rst  = 1'b1;
        x    = 1'b0;
        mode = 2'b00;
        ld   = 1'b0;
        din  = 4'h0;
        model_reset();

        // Gray down, WIDTH=2: 00 -> 10,11,01,00,10 (wrap on 00->10 edges)
        tbl[0]  = '{1'b1, 0, 1'b1, 2'b11, 1'b0, 4'h0, 2, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 0, 1'b1, 2'b11, 1'b0, 4'h0, 3, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 0, 1'b1, 2'b11, 1'b0, 4'h0, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 0, 1'b1, 2'b11, 1'b0, 4'h0, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 0, 1'b1, 2'b11, 1'b0, 4'h0, 2, 1'b0, 1'b1};
        // Binary down, WIDTH=2: 11,10,01,00
        tbl[5]  = '{1'b1, 0, 1'b1, 2'b01, 1'b0, 4'h0, 3, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 0, 1'b1, 2'b01, 1'b0, 4'h0, 2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 0, 1'b1, 2'b01, 1'b0, 4'h0, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 0, 1'b1, 2'b01, 1'b0, 4'h0, 0, 1'b1, 1'b0};
        // Saturation, WIDTH=4 WRAP=0: load E then E,F,F,F
        tbl[9]  = '{1'b1, 3, 1'b0, 2'b00, 1'b1, 4'hE, 14, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3, 1'b1, 2'b00, 1'b0, 4'h0, 15, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 3, 1'b1, 2'b00, 1'b0, 4'h0, 15, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3, 1'b1, 2'b00, 1'b0, 4'h0, 15, 1'b1, 1'b0};
        // Load priority, WIDTH=4 Gray up: ld 5 with x -> 0111, then 0101
        tbl[13] = '{1'b0, 2, 1'b1, 2'b10, 1'b1, 4'h5, 7, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2, 1'b1, 2'b10, 1'b0, 4'h0, 5, 1'b0, 1'b0};

        // Outputs during the power-on reset, before any edge.
        #3;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 15; k++) begin
            if (tbl[k].rst_before)
                do_reset(tbl[k].mode);
            apply(tbl[k].x, tbl[k].mode, tbl[k].ld, tbl[k].din);
            chk("tbl_out", tbl[k].inst, int'(dout[tbl[k].inst]), tbl[k].exp_out);
            chk("tbl_tc", tbl[k].inst, int'(dtc[tbl[k].inst]), int'(tbl[k].exp_tc));
            chk("tbl_wr", tbl[k].inst, int'(dwr[tbl[k].inst]), int'(tbl[k].exp_wr));
        end

        // Mode switch while idle, WIDTH=3: 011 -> 010 and back, count unchanged.
        do_reset(2'b00);
        apply(1'b0, 2'b00, 1'b1, 4'h3);
        chk("idle_bin", 1, int'(out1), 3);
        apply(1'b0, 2'b10, 1'b0, 4'h0);
        chk("idle_gray", 1, int'(out1), 2);
        apply(1'b0, 2'b00, 1'b0, 4'h0);
        chk("idle_back", 1, int'(out1), 3);

        // Asynchronous reset mid-count at cnt=9, then first step gives 1.
        do_reset(2'b00);
        for (int k = 0; k < 9; k++)
            apply(1'b1, 2'b00, 1'b0, 4'h0);
        chk("pre_rst", 2, int'(out2), 9);
        do_reset(2'b00);
        chk("async_out", 2, int'(out2), 0);
        chk("async_wr", 2, int'(wr2), 0);
        apply(1'b1, 2'b00, 1'b0, 4'h0);
        chk("post_rst", 2, int'(out2), 1);

        // Randomized stimulus.
        for (int k = 0; k < 400; k++) begin
            bit       rx;
            bit [1:0] rm;
            bit       rl;
            bit [3:0] rd;
            if ($urandom_range(0, 99) < 2)
                do_reset(2'($urandom_range(0, 3)));
            rx = ($urandom_range(0, 99) < 75);
            rm = ($urandom_range(0, 99) < 85) ? mode : 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 99) < 8);
            rd = 4'($urandom_range(0, 15));
            apply(rx, rm, rl, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
